// File: rtl/tiny_axil_regs.sv
// tiny_axil_regs: AXI4-Lite slave holding four 32-bit control registers
// for the TinyJAMBU core, with a one-cycle write strobe per commit.
module tiny_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic [3:0]                      wr_stb_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    logic          ready_en;
    logic          aw_full;
    logic          w_full;
    logic [1:0]    aw_sel;
    logic [DW-1:0] w_data;
    logic [NB-1:0] w_strb;
    logic          bvalid;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [3:0]    wr_stb;
    logic [DW-1:0] regs [4];

    logic       aw_hs;
    logic       w_hs;
    logic       ar_hs;
    logic       commit;
    logic [1:0] ar_sel;
    logic       unused_ok;

    assign S_AXI_AWREADY = ready_en & ~aw_full;
    assign S_AXI_WREADY  = ready_en & ~w_full;
    assign S_AXI_ARREADY = ready_en & ~rvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;

    assign reg0_o   = regs[0];
    assign reg1_o   = regs[1];
    assign reg2_o   = regs[2];
    assign reg3_o   = regs[3];
    assign wr_stb_o = wr_stb;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign ar_sel = S_AXI_ARADDR[3:2];
    // A pending response blocks the commit, so a full latch pair waits on BREADY.
    assign commit = aw_full & w_full & ~bvalid;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR, S_AXI_ARADDR};

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ready_en <= 1'b0;
            aw_full  <= 1'b0;
            aw_sel   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full <= 1'b1;
                aw_sel  <= S_AXI_AWADDR[3:2];
            end
            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            bvalid <= 1'b0;
            wr_stb <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (commit) begin
                bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
            wr_stb <= commit ? (4'b0001 << aw_sel) : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (commit && aw_sel == 2'(i) && w_strb[b]) begin
                        regs[i][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read capture samples the pre-commit value when both land on one edge.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= regs[ar_sel];
        end else if (S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tiny_axil_regs.sv
// tb_tiny_axil_regs: directed self-checking bench for tiny_axil_regs,
// one task per scenario with hand-computed expectations.
module tb_tiny_axil_regs;

    logic        clk;
    logic        rst;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] reg3;
    logic [3:0]  wr_stb;

    int n_cmp;
    int n_fail;

    tiny_axil_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg0_o        (reg0),
        .reg1_o        (reg1),
        .reg2_o        (reg2),
        .reg3_o        (reg3),
        .wr_stb_o      (wr_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are
    // sampled at the falling edge or 1 unit after the rising edge.
    task automatic axi_aw_w(input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, output bit ok);
        bit aw_done;
        bit w_done;
        bit hs_aw;
        bit hs_w;
        aw_done = 0;
        w_done  = 0;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk);
            #1;
            if (hs_aw) begin
                awvalid = 1'b0;
                aw_done = 1;
            end
            if (hs_w) begin
                wvalid = 1'b0;
                w_done = 1;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        ok = aw_done && w_done;
    endtask

    task automatic wait_b(output logic [3:0] stb, output logic [1:0] resp,
                          output bit ok);
        stb  = 'x;
        resp = 'x;
        ok   = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bvalid) begin
                stb  = wr_stb;
                resp = bresp;
                ok   = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output bit ok);
        bit done;
        bit hs;
        d       = 'x;
        resp    = 'x;
        ok      = 0;
        done    = 0;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk);
            #1;
            if (hs) begin
                arvalid = 1'b0;
                done    = 1;
            end
        end
        arvalid = 1'b0;
        for (int i = 0; i < 40 && done && !ok; i++) begin
            @(negedge clk);
            if (rvalid) begin
                d    = rdata;
                resp = rresp;
                ok   = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 000",
                     {awready, wready, arready});
        end
        n_cmp++;
        if ({bvalid, rvalid, wr_stb} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 000000",
                     {bvalid, rvalid, wr_stb});
        end
        n_cmp++;
        if ({reg0, reg1, reg2, reg3, rdata} !== 160'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h %h %h %h rdata %h want 0",
                     reg0, reg1, reg2, reg3, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_fail++;
            $display("FAIL release_ready_early: got %b want 000",
                     {awready, wready, arready});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL release_ready: got %b want 111",
                     {awready, wready, arready});
        end
    endtask

    task automatic test_seq_write_read;
        bit          ok;
        logic [3:0]  stb;
        logic [1:0]  resp;
        logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = 32'(i + 1);
            axi_aw_w(4'(i * 4), exp, 4'hF, ok);
            wait_b(stb, resp, ok);
            n_cmp++;
            if (stb !== (4'b0001 << i)) begin
                n_fail++;
                $display("FAIL seq_stb%0d: got %b want %b",
                         i, stb, 4'b0001 << i);
            end
            n_cmp++;
            if (resp !== 2'b00) begin
                n_fail++;
                $display("FAIL seq_bresp%0d: got %b want 00", i, resp);
            end
        end
        n_cmp++;
        if ({reg0, reg1, reg2, reg3} !==
            {32'h1, 32'h2, 32'h3, 32'h4}) begin
            n_fail++;
            $display("FAIL seq_regs: got %h %h %h %h want 1 2 3 4",
                     reg0, reg1, reg2, reg3);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 32'(i + 1);
            axi_read(4'(i * 4), d, resp, ok);
            n_cmp++;
            if (d !== exp) begin
                n_fail++;
                $display("FAIL seq_rdata%0d: got %h want %h", i, d, exp);
            end
            n_cmp++;
            if (resp !== 2'b00) begin
                n_fail++;
                $display("FAIL seq_rresp%0d: got %b want 00", i, resp);
            end
        end
    endtask

    task automatic test_strobe;
        bit          ok;
        logic [3:0]  stb;
        logic [1:0]  resp;
        logic [31:0] d;
        axi_aw_w(4'h4, 32'hAABBCCDD, 4'hF, ok);
        wait_b(stb, resp, ok);
        axi_aw_w(4'h4, 32'h11223344, 4'h5, ok);
        wait_b(stb, resp, ok);
        n_cmp++;
        if (reg1 !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL strb_reg1: got %h want aa22cc44", reg1);
        end
        axi_read(4'h4, d, resp, ok);
        n_cmp++;
        if (d !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL strb_read: got %h want aa22cc44", d);
        end
    endtask

    task automatic test_w_before_aw;
        wdata  = 32'hDEADBEEF;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (wready !== 1'b1) begin
            n_fail++;
            $display("FAIL wfirst_wready: got %b want 1", wready);
        end
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        n_cmp++;
        if (wready !== 1'b0) begin
            n_fail++;
            $display("FAIL wfirst_wready_drop: got %b want 0", wready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bvalid, reg2} !== {1'b0, 32'h3}) begin
            n_fail++;
            $display("FAIL wfirst_wait: got bvalid %b reg2 %h want 0 3",
                     bvalid, reg2);
        end
        awaddr  = 4'h8;
        awvalid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (awready !== 1'b1) begin
            n_fail++;
            $display("FAIL wfirst_awready: got %b want 1", awready);
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        n_cmp++;
        if ({bvalid, wr_stb} !== 5'b0) begin
            n_fail++;
            $display("FAIL wfirst_early: got bvalid %b stb %b want 0 0000",
                     bvalid, wr_stb);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bvalid, wr_stb, reg2} !== {1'b1, 4'b0100, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL wfirst_commit: got %b %b %h want 1 0100 deadbeef",
                     bvalid, wr_stb, reg2);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bvalid, wr_stb} !== 5'b0) begin
            n_fail++;
            $display("FAIL wfirst_after: got bvalid %b stb %b want 0 0000",
                     bvalid, wr_stb);
        end
    endtask

    task automatic test_bready_hold;
        bit ok;
        bready = 1'b0;
        axi_aw_w(4'hC, 32'h12345678, 4'hF, ok);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if ({bvalid, reg3} !== {1'b1, 32'h12345678}) begin
            n_fail++;
            $display("FAIL hold_bvalid: got %b %h want 1 12345678",
                     bvalid, reg3);
        end
        axi_aw_w(4'hC, 32'hCAFEF00D, 4'hF, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_latch_hs: got %b want 1", ok);
        end
        n_cmp++;
        if ({awready, wready, wr_stb, reg3} !==
            {2'b00, 4'b0000, 32'h12345678}) begin
            n_fail++;
            $display("FAIL hold_blocked: got %b%b %b %h want 00 0000 12345678",
                     awready, wready, wr_stb, reg3);
        end
        bready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bvalid, reg3} !== {1'b0, 32'h12345678}) begin
            n_fail++;
            $display("FAIL hold_bhs: got %b %h want 0 12345678", bvalid, reg3);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bvalid, wr_stb, reg3} !== {1'b1, 4'b1000, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL hold_commit: got %b %b %h want 1 1000 cafef00d",
                     bvalid, wr_stb, reg3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_same_edge;
        bit          ok;
        logic [3:0]  stb;
        logic [1:0]  resp;
        logic [31:0] d;
        axi_aw_w(4'h4, 32'h2, 4'hF, ok);
        wait_b(stb, resp, ok);
        awaddr  = 4'h4;
        wdata   = 32'h55;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = 4'h4;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n_cmp++;
        if ({rvalid, rdata, bvalid, reg1} !==
            {1'b1, 32'h2, 1'b1, 32'h55}) begin
            n_fail++;
            $display("FAIL same_edge: got rv %b rd %h bv %b reg1 %h want 1 2 1 55",
                     rvalid, rdata, bvalid, reg1);
        end
        rready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({rvalid, bvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL same_edge_drain: got %b%b want 00", rvalid, bvalid);
        end
        axi_read(4'h4, d, resp, ok);
        n_cmp++;
        if (d !== 32'h55) begin
            n_fail++;
            $display("FAIL same_edge_reread: got %h want 55", d);
        end
    endtask

    task automatic test_reset_midflight;
        bit ok;
        bready = 1'b0;
        rready = 1'b0;
        axi_aw_w(4'h0, 32'h99, 4'hF, ok);
        araddr  = 4'h8;
        arvalid = 1'b1;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n_cmp++;
        if ({bvalid, rvalid, wr_stb} !== 6'b11_0001) begin
            n_fail++;
            $display("FAIL mid_pending: got bv %b rv %b stb %b want 1 1 0001",
                     bvalid, rvalid, wr_stb);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bvalid, rvalid, wr_stb, awready, wready, arready} !== 9'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: got %b %b %b %b%b%b want all 0",
                     bvalid, rvalid, wr_stb, awready, wready, arready);
        end
        n_cmp++;
        if ({reg0, reg1, reg2, reg3, rdata} !== 160'b0) begin
            n_fail++;
            $display("FAIL mid_reset_regs: got %h %h %h %h rdata %h want 0",
                     reg0, reg1, reg2, reg3, rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_release_early: got %b want 000",
                     {awready, wready, arready});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            n_fail++;
            $display("FAIL mid_release: got %b want 11100",
                     {awready, wready, arready, bvalid, rvalid});
        end
        bready = 1'b1;
        rready = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        test_reset();
        test_seq_write_read();
        test_strobe();
        test_w_before_aw();
        test_bready_hold();
        test_same_edge();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
